// File: rtl/adc_spi_capture_pkg.sv
// Shared definitions for the serial ADC capture block: frame geometry and FSM states.
package adc_spi_capture_pkg;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned LEAD_BITS  = 4;
   localparam int unsigned ADC_W      = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      QUIET = 2'd2
   } state_t;

endpackage

// File: rtl/adc_spi_capture_shift_in_register.sv
// Serial-in, parallel-out register collecting one ADC frame, MSB first.
module shift_in_register
   import adc_spi_capture_pkg::*;
#(
   parameter int unsigned W = FRAME_BITS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         shift_en,
   input  logic         sdata,
   output logic [W-1:0] data
);

   // Shift one bit in at the LSB on each enabled cycle; clear wipes the previous frame.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         data <= '0;
      end else if (shift_en) begin
         data <= {data[W-2:0], sdata};
      end
   end

endmodule

// File: rtl/adc_spi_capture.sv
// SPI-style capture of a 16-bit ADC frame: 4 leading bits (must be zero) plus a
// 12-bit sample, of which the upper N bits are presented on data_out.
module adc_spi_capture
   import adc_spi_capture_pkg::*;
#(
   parameter int unsigned N       = 8,
   parameter int unsigned CLK_DIV = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         sdata,
   output logic         cs_n,
   output logic         sclk,
   output logic [N-1:0] data_out,
   output logic         done,
   output logic         load_n,
   output logic         busy,
   output logic         frame_err
);

   localparam int unsigned DIV_W = $clog2(2 * CLK_DIV) + 1;
   localparam int unsigned BIT_W = $clog2(FRAME_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] QUIET_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

   state_t                  state_q;
   state_t                  state_d;
   logic [DIV_W-1:0]        cnt_q;
   logic [BIT_W-1:0]        bit_cnt_q;
   logic                    sclk_q;
   logic                    sample_edge;
   logic                    last_bit;
   logic                    clear;
   logic [FRAME_BITS-1:0]   sr_q;
   logic [FRAME_BITS-1:0]   frame_word;
   logic                    unused_bits;

   // The 16th bit is still on sdata at the final sample edge, so the result is
   // taken from the register contents with that bit appended.
   assign sample_edge = (state_q == SHIFT) && !sclk_q && (cnt_q == DIV_LAST);
   assign last_bit    = sample_edge && (bit_cnt_q == BIT_LAST);
   assign frame_word  = {sr_q[FRAME_BITS-2:0], sdata};
   assign sclk        = sclk_q;
   assign load_n      = ~done;
   assign unused_bits = ^{sr_q[FRAME_BITS-1], frame_word};

   shift_in_register #(
      .W (FRAME_BITS)
   ) u_shift_in (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .shift_en (sample_edge),
      .sdata    (sdata),
      .data     (sr_q)
   );

   // Frame sequencing: next state plus the state-decoded outputs.
   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      cs_n    = (state_q != SHIFT);
      busy    = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               clear   = 1'b1;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               state_d = QUIET;
            end
         end
         QUIET: begin
            if (cnt_q == QUIET_LAST) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // sclk divider and bit counter; cnt_q doubles as the QUIET interval timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         sclk_q    <= 1'b1;
      end else if ((state_q == SHIFT) && !last_bit) begin
         if (cnt_q == DIV_LAST) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
            if (sample_edge) begin
               bit_cnt_q <= bit_cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if ((state_q == QUIET) && (state_d == QUIET)) begin
         cnt_q <= cnt_q + 1'b1;
      end else begin
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         sclk_q    <= 1'b1;
      end
   end

   // Result registers: updated only on the final sample edge, held otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out  <= '0;
         frame_err <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= last_bit;
         if (last_bit) begin
            data_out  <= frame_word[ADC_W-1 -: N];
            frame_err <= |frame_word[FRAME_BITS-1 -: LEAD_BITS];
         end
      end
   end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Self-checking bench for adc_spi_capture (N=8, CLK_DIV=2) with a behavioural frame model.
module tb_adc_spi_capture;

   localparam int unsigned N         = 8;
   localparam int unsigned CLK_DIV   = 2;
   localparam int          FRAME_CYC = 32 * CLK_DIV;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         sdata = 1'b0;
   logic         cs_n;
   logic         sclk;
   logic [N-1:0] data_out;
   logic         done;
   logic         load_n;
   logic         busy;
   logic         frame_err;

   int checks        = 0;
   int errors        = 0;
   int cyc           = 0;
   int last_done_abs = 0;

   adc_spi_capture #(
      .N       (N),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sdata     (sdata),
      .cs_n      (cs_n),
      .sclk      (sclk),
      .data_out  (data_out),
      .done      (done),
      .load_n    (load_n),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: sample is the low 12 bits of the frame, data_out its top N bits.
   function automatic logic [N-1:0] model_data(input logic [15:0] w);
      logic [11:0] s;
      s = w[11:0];
      return N'(s >> (12 - N));
   endfunction

   function automatic logic model_err(input logic [15:0] w);
      return (w[15:12] != 4'd0);
   endfunction

   task automatic check_reset(input string p);
      check({p, "_cs_n"},      32'(cs_n),      32'd1);
      check({p, "_sclk"},      32'(sclk),      32'd1);
      check({p, "_data_out"},  32'(data_out),  32'd0);
      check({p, "_done"},      32'(done),      32'd0);
      check({p, "_load_n"},    32'(load_n),    32'd1);
      check({p, "_busy"},      32'(busy),      32'd0);
      check({p, "_frame_err"}, 32'(frame_err), 32'd0);
   endtask

   // Requests one frame and plays the ADC side: a new bit after every sclk fall,
   // garbage right after every rise. abort_k>0 resets on the abort_k-th sample edge.
   task automatic do_frame(input logic [15:0] w, input bit keep_start, input bit extra_pulse,
                           input bit check_gap, input int abort_k);
      int           c;
      int           idx;
      int           run;
      int           rises;
      int           dones;
      int           done_c;
      int           wait_n;
      logic         prev_s;
      logic         prev_cs;
      bit           phase_bad;
      logic         ld_at_done;
      logic [N-1:0] d_at;
      logic         e_at;
      start  = 1'b1;
      wait_n = 0;
      while (cs_n !== 1'b0 && wait_n < 100) begin
         tick();
         wait_n++;
      end
      if (cs_n !== 1'b0) begin
         check("cs_fall_timeout", 32'd0, 32'd1);
         start = 1'b0;
         return;
      end
      if (check_gap) check("cs_gap", 32'(cyc - last_done_abs), 32'(2 * CLK_DIV + 1));
      if (!keep_start) start = 1'b0;
      check("sclk_at_fall", 32'(sclk), 32'd1);
      c = 0; idx = 0; run = 1; rises = 0; dones = 0; done_c = -1;
      phase_bad = 1'b0; ld_at_done = 1'b1; d_at = '0; e_at = 1'b0;
      while (c < FRAME_CYC + 1) begin
         prev_s  = sclk;
         prev_cs = cs_n;
         if (extra_pulse && c == 20) start = 1'b1;
         if (extra_pulse && c == 22) start = 1'b0;
         if (abort_k > 0 && c == 2 * CLK_DIV * abort_k - 1) reset = 1'b1;
         tick();
         c++;
         if (abort_k > 0 && reset) begin
            reset = 1'b0;
            check("abort_cs_n", 32'(cs_n),     32'd1);
            check("abort_done", 32'(done),     32'd0);
            check("abort_busy", 32'(busy),     32'd0);
            check("abort_data", 32'(data_out), 32'd0);
            break;
         end
         if (prev_cs === 1'b0) begin
            if (sclk !== prev_s || cs_n !== 1'b0) begin
               if (run != CLK_DIV) phase_bad = 1'b1;
               run = 1;
            end else begin
               run++;
            end
            if (prev_s === 1'b0 && sclk === 1'b1) rises++;
         end
         if (cs_n === 1'b0 && prev_s === 1'b1 && sclk === 1'b0) begin
            if (idx < 16) sdata = w[15 - idx];
            idx++;
         end else if (cs_n === 1'b0 && prev_s === 1'b0 && sclk === 1'b1) begin
            sdata = 1'($urandom);
         end
         if (done === 1'b1) begin
            dones++;
            if (done_c < 0) begin
               done_c        = c;
               last_done_abs = cyc;
               d_at          = data_out;
               e_at          = frame_err;
               ld_at_done    = load_n;
            end
         end
      end
      if (abort_k > 0) begin
         dones = 0;
         for (int i = 0; i < 80; i++) begin
            tick();
            if (done === 1'b1) dones++;
         end
         check("abort_no_done", 32'(dones), 32'd0);
         check("abort_idle_cs", 32'(cs_n),  32'd1);
         return;
      end
      check("done_latency",   32'(done_c),     32'(FRAME_CYC));
      check("done_pulses",    32'(dones),      32'd1);
      check("data_out",       32'(d_at),       32'(model_data(w)));
      check("frame_err",      32'(e_at),       32'(model_err(w)));
      check("load_n_at_done", 32'(ld_at_done), 32'd0);
      check("sclk_rises",     32'(rises),      32'd16);
      check("sclk_phase",     32'(phase_bad),  32'd0);
      check("load_n_after",   32'(load_n),     32'd1);
      check("busy_quiet",     32'(busy),       32'd1);
   endtask

   initial begin
      logic [15:0] w;
      bit          quiet;

      reset = 1'b1;
      repeat (3) tick();
      check_reset("por");
      reset = 1'b0;
      repeat (4) tick();

      do_frame(16'h0B69, 1'b0, 1'b0, 1'b0, 0);
      repeat (6) tick();
      check("hold_data", 32'(data_out),  32'(model_data(16'h0B69)));
      check("hold_err",  32'(frame_err), 32'(model_err(16'h0B69)));

      do_frame(16'h4FFF, 1'b0, 1'b0, 1'b0, 0);
      repeat (8) tick();
      check("hold_err_set", 32'(frame_err), 32'd1);

      reset = 1'b1;
      tick();
      check_reset("idle_rst");
      reset = 1'b0;
      tick();

      for (int i = 0; i < 3; i++) begin
         w = 16'($urandom);
         if (i == 1) w[15:12] = 4'd0;
         do_frame(w, 1'b0, 1'b1, 1'b0, 0);
         quiet = 1'b1;
         repeat (20) begin
            tick();
            if (cs_n !== 1'b1) quiet = 1'b0;
         end
         check("no_queued_start", 32'(quiet), 32'd1);
      end

      for (int i = 0; i < 3; i++) begin
         w = 16'($urandom);
         if (i != 1) w[15:12] = 4'd0;
         do_frame(w, (i < 2), 1'b0, (i > 0), 0);
      end
      repeat (10) tick();

      do_frame(16'($urandom), 1'b0, 1'b0, 1'b0, 9);
      w = 16'($urandom);
      w[15:12] = 4'd0;
      do_frame(w, 1'b0, 1'b0, 1'b0, 0);
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
